// File: rtl/pipe_mem.sv
// pipe_mem -- dual-port word memory with a read-only instruction port and a
// read/write data port, each with a fixed-latency, fully pipelined read path.
//
// Ports
//   clk, resetn            single clock, asynchronous active-low reset
//   if_req/if_addr         instruction read request (byte address)
//   if_ready               request can be accepted this cycle
//   if_rvalid/if_rdata     read response, RD_LATENCY cycles after accept
//   dm_req/dm_we/dm_wstrb  data request, write select, byte write enables
//   dm_addr/dm_wdata       data byte address and write data
//   dm_ready               request can be accepted this cycle
//   dm_rvalid/dm_rdata     read response, RD_LATENCY cycles after accept
//   dm_wack                one-cycle pulse the cycle after a write accept
//
// DATA_WIDTH must be 32 or 64 and RD_LATENCY 1..4. The memory array is never
// reset, so its contents survive a reset.

// One read-response pipeline. Data is zeroed when no read is accepted so the
// output data is all zeros whenever valid is low without extra output gating.
module pipe_mem_rdpipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  acc,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);
    // vld_pipe[k] / dat_pipe[k]: a read accepted k edges ago
    logic [RD_LATENCY:1]                 vld_pipe;
    logic [RD_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= acc;
            dat_pipe[1] <= acc ? din : '0;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign rvalid = vld_pipe[RD_LATENCY];
    assign rdata  = dat_pipe[RD_LATENCY];
endmodule

module pipe_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ready,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    output logic                    dm_ready,
    output logic                    dm_rvalid,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_wack
);
    localparam int STRB  = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(STRB);
    localparam int IDX_W = ADDR_WIDTH - OFF;
    localparam int DEPTH = 1 << IDX_W;

    logic                  ready_q;
    logic                  if_acc, dm_wr, dm_rd;
    logic [IDX_W-1:0]      if_idx, dm_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-offset bits select nothing; misaligned addresses simply alias.
    logic unused_lsb;
    assign unused_lsb = ^{if_addr[OFF-1:0], dm_addr[OFF-1:0]};

    assign if_idx = if_addr[ADDR_WIDTH-1:OFF];
    assign dm_idx = dm_addr[ADDR_WIDTH-1:OFF];

    // Shared ready: low in reset, high from the first edge after release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ready_q <= 1'b0;
        else         ready_q <= 1'b1;
    end

    assign if_ready = ready_q;
    assign dm_ready = ready_q;

    assign if_acc = if_req & ready_q;
    assign dm_wr  = dm_req & ready_q & dm_we;
    assign dm_rd  = dm_req & ready_q & ~dm_we;

    // Byte-masked write. Reads sample mem at the same edge through the
    // pipeline registers, so a same-edge read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (dm_wr) begin
            for (int b = 0; b < STRB; b++) begin
                if (dm_wstrb[b]) mem[dm_idx][8*b +: 8] <= dm_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) dm_wack <= 1'b0;
        else         dm_wack <= dm_wr;
    end

    // Port 0 = instruction, port 1 = data
    logic [1:0]                 acc, rv;
    logic [1:0][DATA_WIDTH-1:0] rword, rd;

    assign acc   = {dm_rd, if_acc};
    assign rword = {mem[dm_idx], mem[if_idx]};

    for (genvar p = 0; p < 2; p++) begin : g_port
        pipe_mem_rdpipe #(
            .DATA_WIDTH (DATA_WIDTH),
            .RD_LATENCY (RD_LATENCY)
        ) u_rp (
            .clk    (clk),
            .resetn (resetn),
            .acc    (acc[p]),
            .din    (rword[p]),
            .rvalid (rv[p]),
            .rdata  (rd[p])
        );
    end

    assign if_rvalid = rv[0];
    assign if_rdata  = rd[0];
    assign dm_rvalid = rv[1];
    assign dm_rdata  = rd[1];
endmodule

// File: tb/tb_pipe_mem.sv
// Bench for pipe_mem (64-bit words, RD_LATENCY 3). Stimulus updates an array
// model of memory and queues expected responses with the cycle they are due;
// a negedge monitor checks every output each cycle against those queues.
module tb_pipe_mem;
    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0, dm_we = 1'b0;
    logic [7:0]    dm_wstrb = '0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_ready, dm_rvalid, dm_wack;
    logic [DW-1:0] dm_rdata;

    pipe_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .dm_wack(dm_wack)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] d; int due; } exp_t;

    exp_t        if_q[$], dm_q[$];
    int          wack_q[$];
    logic [63:0] ref_mem [128];
    int          cyc = 0;
    int          rel_cyc = 0;
    int          n_chk = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle, each output must match what the model says is due.
    always @(negedge clk) begin
        chk("if_ready", 64'(if_ready), 64'(resetn && (cyc > rel_cyc)));
        chk("dm_ready", 64'(dm_ready), 64'(resetn && (cyc > rel_cyc)));
        if (if_q.size() > 0 && if_q[0].due == cyc) begin
            chk("if_rvalid", 64'(if_rvalid), 64'd1);
            chk("if_rdata", if_rdata, if_q[0].d);
            void'(if_q.pop_front());
        end else begin
            chk("if_rvalid_idle", 64'(if_rvalid), 64'd0);
            chk("if_rdata_idle", if_rdata, 64'd0);
        end
        if (dm_q.size() > 0 && dm_q[0].due == cyc) begin
            chk("dm_rvalid", 64'(dm_rvalid), 64'd1);
            chk("dm_rdata", dm_rdata, dm_q[0].d);
            void'(dm_q.pop_front());
        end else begin
            chk("dm_rvalid_idle", 64'(dm_rvalid), 64'd0);
            chk("dm_rdata_idle", dm_rdata, 64'd0);
        end
        if (wack_q.size() > 0 && wack_q[0] == cyc) begin
            chk("dm_wack", 64'(dm_wack), 64'd1);
            void'(wack_q.pop_front());
        end else begin
            chk("dm_wack_idle", 64'(dm_wack), 64'd0);
        end
    end

    // Present one cycle of requests (called #1 after a rising edge) and
    // record what the model expects from them. Reads see memory before any
    // write in the same cycle.
    task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                         input logic we, input logic [7:0] st,
                         input logic [AW-1:0] da, input logic [63:0] wd);
        logic rdy;
        rdy      = resetn && (cyc > rel_cyc);
        if_req   = ir;  if_addr  = ia;
        dm_req   = dr;  dm_we    = we;  dm_wstrb = st;
        dm_addr  = da;  dm_wdata = wd;
        if (ir && rdy) if_q.push_back('{ref_mem[ia[9:3]], cyc + LAT});
        if (dr && rdy) begin
            if (we) begin
                for (int b = 0; b < 8; b++)
                    if (st[b]) ref_mem[da[9:3]][8*b +: 8] = wd[8*b +: 8];
                wack_q.push_back(cyc + 1);
            end else begin
                dm_q.push_back('{ref_mem[da[9:3]], cyc + LAT});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] st, input logic [63:0] d);
        drive(1'b0, '0, 1'b1, 1'b1, st, a, d);
    endtask

    initial begin
        // Reset held three cycles; requests during reset must be ignored.
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 10'h000, 1'b1, 1'b1, 8'hFF, 10'h000, 64'hBAD);
        drive(1'b1, 10'h008, 1'b1, 1'b0, 8'h00, 10'h008, 64'h0);
        rel_cyc = cyc;
        resetn  = 1'b1;
        idle(2);

        // Preload every word with a known random value.
        for (int w = 0; w < 128; w++) wr(10'(w * 8), 8'hFF, {$urandom, $urandom});

        // Byte strobes: expect 0xAA22CC44 in the low half.
        wr(10'h040, 8'hFF, 64'hAABBCCDD);
        wr(10'h040, 8'h05, 64'h11223344);
        drive(1'b0, '0, 1'b1, 1'b0, 8'h00, 10'h040, '0);
        // Zero strobe: acknowledged, no change.
        wr(10'h040, 8'h00, '1);
        drive(1'b1, 10'h040, 1'b1, 1'b0, 8'h00, 10'h044, '0);
        idle(LAT);

        // Same-edge collision, then read-after-write on both ports.
        wr(10'h028, 8'hFF, 64'h0);
        drive(1'b1, 10'h028, 1'b1, 1'b1, 8'hFF, 10'h028, 64'h12345678);
        drive(1'b1, 10'h028, 1'b1, 1'b0, 8'h00, 10'h028, '0);
        idle(LAT);

        // Back-to-back reads: responses on consecutive cycles, in order.
        for (int w = 0; w < 4; w++) wr(10'(w * 8), 8'hFF, 64'(w + 1));
        for (int w = 0; w < 4; w++) drive(1'b1, 10'(w * 8), 1'b1, 1'b0, 8'h00, 10'(w * 8), '0);
        idle(LAT);

        // Address LSBs ignored.
        wr(10'h013, 8'hFF, 64'h0123456789ABCDEF);
        drive(1'b1, 10'h010, 1'b1, 1'b0, 8'h00, 10'h017, '0);
        idle(LAT);

        // Reset two cycles after the first of two accepted reads: both
        // responses are dropped; a write during reset is ignored.
        drive(1'b1, 10'h000, 1'b1, 1'b0, 8'h00, 10'h008, '0);
        drive(1'b1, 10'h010, 1'b0, 1'b0, 8'h00, 10'h000, '0);
        resetn = 1'b0;
        if_q.delete(); dm_q.delete(); wack_q.delete();
        drive(1'b1, 10'h018, 1'b1, 1'b1, 8'hFF, 10'h100, 64'hDEADBEEF);
        drive(1'b1, 10'h018, 1'b1, 1'b1, 8'hFF, 10'h000, 64'hDEADBEEF);
        rel_cyc = cyc;
        resetn  = 1'b1;
        idle(LAT + 3);
        drive(1'b1, 10'h000, 1'b1, 1'b0, 8'h00, 10'h100, '0);
        drive(1'b1, 10'h010, 1'b1, 1'b0, 8'h00, 10'h008, '0);
        idle(LAT);

        // Random traffic on both ports.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
                  10'($urandom_range(0, 1023)), {$urandom, $urandom});
        end
        idle(LAT + 3);

        n_chk++;
        if (if_q.size() + dm_q.size() + wack_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_responses got=%0d exp=0", if_q.size() + dm_q.size() + wack_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
